// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX operand select, bypass and ALU-op decode, registered into EX
//   Build option: define EX_OPERAND_FORWARD_EN to enable the MEM/WB operand bypass;
//   without it the *_fwd_* inputs are ignored and operands come straight from the register file.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     in_*                     decoded instruction from ID
//     stall, flush             hold the stage / kill the captured instruction (flush wins)
//     mem_fwd_*, wb_fwd_*      writeback bypass from EX/MEM and MEM/WB
//     ex_valid, ex_d1, ex_d2   registered ALU operands
//     ex_control               registered ALU op code
//     ex_rd_addr, ex_reg_write, ex_store_data, ex_illegal   registered side-band
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [XLEN-1:0] in_imm,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_b5,
    input  logic [4:0]      in_rd_addr,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_fwd_valid,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_d1,
    output logic [XLEN-1:0] ex_d2,
    output logic [3:0]      ex_control,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_illegal
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b1000;

    logic [XLEN-1:0] w_rs1, w_rs2, w_d1, w_d2;
    logic [3:0]      w_ctrl;
    logic            w_ill, w_wr, w_reg_write;
    logic            r_valid, r_reg_write, r_illegal;
    logic [XLEN-1:0] r_d1, r_d2, r_store_data;
    logic [3:0]      r_control;
    logic [4:0]      r_rd_addr;

    // x0 reads as zero regardless of any bypass hit
`ifdef EX_OPERAND_FORWARD_EN
    assign w_rs1 = (in_rs1_addr == 5'd0) ? '0 :
                   (mem_fwd_valid && mem_fwd_rd == in_rs1_addr) ? mem_fwd_data :
                   (wb_fwd_valid && wb_fwd_rd == in_rs1_addr) ? wb_fwd_data : in_rs1_data;
    assign w_rs2 = (in_rs2_addr == 5'd0) ? '0 :
                   (mem_fwd_valid && mem_fwd_rd == in_rs2_addr) ? mem_fwd_data :
                   (wb_fwd_valid && wb_fwd_rd == in_rs2_addr) ? wb_fwd_data : in_rs2_data;
`else
    logic w_unused;
    assign w_unused = ^{mem_fwd_valid, mem_fwd_rd, mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data};
    assign w_rs1 = (in_rs1_addr == 5'd0) ? '0 : in_rs1_data;
    assign w_rs2 = (in_rs2_addr == 5'd0) ? '0 : in_rs2_data;
`endif

    // Illegal encodings leave operands at zero and the op at ADD
    always_comb begin
        w_d1   = '0;
        w_d2   = '0;
        w_ctrl = ALU_ADD;
        w_ill  = 1'b0;
        w_wr   = 1'b0;
        case (in_opcode)
            OP_R: begin
                // funct7_b5 is only meaningful for SUB and SRA
                if (!in_funct7_b5 || in_funct3 == 3'b000 || in_funct3 == 3'b101) begin
                    w_d1   = w_rs1;
                    w_d2   = w_rs2;
                    w_ctrl = {in_funct7_b5, in_funct3};
                    w_wr   = 1'b1;
                end else begin
                    w_ill = 1'b1;
                end
            end
            OP_IMM: begin
                // imm[30] only selects SRAI; ADDI never becomes SUB
                w_d1   = w_rs1;
                w_d2   = in_imm;
                w_ctrl = {in_funct7_b5 & (in_funct3 == 3'b101), in_funct3};
                w_wr   = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
                w_d1 = w_rs1;
                w_d2 = in_imm;
                w_wr = (in_opcode == OP_LOAD);
            end
            OP_BRANCH: begin
                if (in_funct3[2:1] == 2'b01) begin
                    w_ill = 1'b1;
                end else begin
                    w_d1   = w_rs1;
                    w_d2   = w_rs2;
                    w_ctrl = !in_funct3[2] ? ALU_SUB : in_funct3[1] ? ALU_SLTU : ALU_SLT;
                end
            end
            OP_LUI: begin
                w_d2 = in_imm;
                w_wr = 1'b1;
            end
            OP_AUIPC: begin
                w_d1 = in_pc;
                w_d2 = in_imm;
                w_wr = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                w_d1 = in_pc;
                w_d2 = XLEN'(4);
                w_wr = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign w_reg_write = in_valid && (in_rd_addr != 5'd0) && w_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            r_valid      <= 1'b0;
            r_d1         <= '0;
            r_d2         <= '0;
            r_control    <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_store_data <= '0;
            r_illegal    <= 1'b0;
        end else if (!stall) begin
            r_valid      <= in_valid;
            r_d1         <= w_d1;
            r_d2         <= w_d2;
            r_control    <= w_ctrl;
            r_rd_addr    <= in_rd_addr;
            r_reg_write  <= w_reg_write;
            r_store_data <= w_rs2;
            r_illegal    <= w_ill;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_d1         = r_d1;
    assign ex_d2         = r_d2;
    assign ex_control    = r_control;
    assign ex_rd_addr    = r_rd_addr;
    assign ex_reg_write  = r_reg_write;
    assign ex_store_data = r_store_data;
    assign ex_illegal    = r_illegal;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed and random checks of ex_operand_stage against a reference model
module tb_ex_operand_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_funct7_b5 = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic        mem_fwd_valid = 1'b0, wb_fwd_valid = 1'b0;
    logic [4:0]  mem_fwd_rd = '0, wb_fwd_rd = '0;
    logic [31:0] mem_fwd_data = '0, wb_fwd_data = '0;
    logic        ex_valid, ex_reg_write, ex_illegal;
    logic [31:0] ex_d1, ex_d2, ex_store_data;
    logic [3:0]  ex_control;
    logic [4:0]  ex_rd_addr;
    int checks = 0, errors = 0;

    typedef struct {
        logic v, rw, ill;
        logic [31:0] d1, d2, sd;
        logic [3:0] c;
        logic [4:0] rd;
    } exp_t;
    exp_t e;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_imm(in_imm),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
        .in_rd_addr(in_rd_addr), .stall(stall), .flush(flush),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_d1(ex_d1), .ex_d2(ex_d2), .ex_control(ex_control),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t zero_exp();
        exp_t z;
        z.v = 0; z.rw = 0; z.ill = 0; z.d1 = 0; z.d2 = 0; z.sd = 0; z.c = 0; z.rd = 0;
        return z;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'd0;
`ifdef EX_OPERAND_FORWARD_EN
        if (mem_fwd_valid && mem_fwd_rd == a) return mem_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == a) return wb_fwd_data;
`endif
        return rf;
    endfunction

    // Reference: what the EX stage should latch for the current ID inputs
    function automatic exp_t model();
        exp_t m = zero_exp();
        logic [31:0] a = operand(in_rs1_addr, in_rs1_data);
        logic [31:0] b = operand(in_rs2_addr, in_rs2_data);
        logic [3:0] br [8] = '{4'd8, 4'd8, 4'd0, 4'd0, 4'd2, 4'd2, 4'd3, 4'd3};
        logic [3:0] rc = {in_funct7_b5, in_funct3};
        bit wr = 0;
        m.v = in_valid; m.rd = in_rd_addr; m.sd = b;
        case (in_opcode)
            7'h33: if (rc inside {0, 1, 2, 3, 4, 5, 6, 7, 8, 13}) begin
                m.d1 = a; m.d2 = b; m.c = rc; wr = 1;
            end else m.ill = 1;
            7'h13: begin m.d1 = a; m.d2 = in_imm; m.c = (in_funct3 == 5) ? rc : {1'b0, in_funct3}; wr = 1; end
            7'h03: begin m.d1 = a; m.d2 = in_imm; wr = 1; end
            7'h23: begin m.d1 = a; m.d2 = in_imm; end
            7'h63: if (in_funct3 == 2 || in_funct3 == 3) m.ill = 1;
                   else begin m.d1 = a; m.d2 = b; m.c = br[in_funct3]; end
            7'h37: begin m.d2 = in_imm; wr = 1; end
            7'h17: begin m.d1 = in_pc; m.d2 = in_imm; wr = 1; end
            7'h6f, 7'h67: begin m.d1 = in_pc; m.d2 = 4; wr = 1; end
            default: m.ill = 1;
        endcase
        m.rw = in_valid && in_rd_addr != 0 && wr;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(e.v));
        chk({tag, ".d1"}, ex_d1, e.d1);
        chk({tag, ".d2"}, ex_d2, e.d2);
        chk({tag, ".ctrl"}, 32'(ex_control), 32'(e.c));
        chk({tag, ".rd"}, 32'(ex_rd_addr), 32'(e.rd));
        chk({tag, ".rw"}, 32'(ex_reg_write), 32'(e.rw));
        chk({tag, ".sd"}, ex_store_data, e.sd);
        chk({tag, ".ill"}, 32'(ex_illegal), 32'(e.ill));
    endtask

    task automatic step(input string tag, input logic s, input logic f);
        stall = s; flush = f;
        if (f) e = zero_exp();
        else if (!s) e = model();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] r1, input logic [31:0] d1v,
                         input logic [4:0] r2, input logic [31:0] d2v,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        in_valid = 1; in_opcode = op; in_funct3 = f3; in_funct7_b5 = f7;
        in_rs1_addr = r1; in_rs1_data = d1v; in_rs2_addr = r2; in_rs2_data = d2v;
        in_imm = imm; in_pc = pc; in_rd_addr = rd;
    endtask

    task automatic rand_inputs();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h7f};
        in_valid = ($urandom_range(0, 3) != 0);
        in_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
        in_funct3 = 3'($urandom); in_funct7_b5 = 1'($urandom);
        in_rs1_addr = 5'($urandom_range(0, 5)); in_rs2_addr = 5'($urandom_range(0, 5));
        in_rd_addr = 5'($urandom_range(0, 5));
        in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom; in_pc = $urandom;
        mem_fwd_valid = 1'($urandom); mem_fwd_rd = 5'($urandom_range(0, 5)); mem_fwd_data = $urandom;
        wb_fwd_valid = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 5)); wb_fwd_data = $urandom;
    endtask

    initial begin
        e = zero_exp();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;
        // ADD x?, rs1=5, rs2=7
        instr(7'h33, 3'b000, 0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 32'd0, 5'd9);
        step("add", 0, 0);
        chk("add.ctrl_const", 32'(ex_control), 32'd0);
        chk("add.d1_const", ex_d1, 32'd5);
        // SRAI / ADDI with bit 30 set
        instr(7'h13, 3'b101, 1, 5'd1, 32'h8000_0000, 5'd0, 32'd0, 32'h403, 32'd0, 5'd4);
        step("srai", 0, 0);
        chk("srai.ctrl_const", 32'(ex_control), 32'hd);
        instr(7'h13, 3'b000, 1, 5'd1, 32'd1, 5'd0, 32'd0, 32'h400, 32'd0, 5'd4);
        step("addi", 0, 0);
        chk("addi.ctrl_const", 32'(ex_control), 32'd0);
        // bypass priority and x0
        instr(7'h33, 3'b000, 0, 5'd3, 32'h11, 5'd3, 32'h22, 32'd0, 32'd0, 5'd5);
        mem_fwd_valid = 1; mem_fwd_rd = 3; mem_fwd_data = 32'hAA;
        wb_fwd_valid = 1; wb_fwd_rd = 3; wb_fwd_data = 32'hBB;
        step("fwd_mem", 0, 0);
        mem_fwd_valid = 0;
        step("fwd_wb", 0, 0);
        mem_fwd_valid = 1; in_rs1_addr = 0;
        step("fwd_x0", 0, 0);
        chk("fwd_x0.d1_const", ex_d1, 32'd0);
        // stall for 3 cycles while bypass and ID inputs move, then flush under stall
        in_rs1_addr = 3;
        step("pre_stall", 0, 0);
        for (int i = 0; i < 3; i++) begin
            mem_fwd_data = $urandom; wb_fwd_data = $urandom; in_rs1_data = $urandom;
            step("stall", 1, 0);
        end
        step("flush_stall", 1, 1);
        chk("flush.valid_const", 32'(ex_valid), 32'd0);
        // async reset mid-stall, between edges
        instr(7'h37, 3'b000, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd7);
        step("lui", 0, 0);
        step("lui_hold", 1, 0);
        #2 rst = 1;
        #1 e = zero_exp();
        check_all("async_rst");
        #1 rst = 0;
        step("post_rst", 0, 0);
        // illegal opcode, BLTU, JAL
        instr(7'h7f, 3'b000, 0, 5'd1, 32'd9, 5'd2, 32'd9, 32'd9, 32'd0, 5'd6);
        step("illegal", 0, 0);
        chk("illegal.ill_const", 32'(ex_illegal), 32'd1);
        instr(7'h63, 3'b110, 0, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 32'h10, 32'd0, 5'd0);
        mem_fwd_valid = 0; wb_fwd_valid = 0;
        step("bltu", 0, 0);
        chk("bltu.ctrl_const", 32'(ex_control), 32'd3);
        instr(7'h6f, 3'b000, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h20, 32'h100, 5'd1);
        step("jal", 0, 0);
        chk("jal.d1_const", ex_d1, 32'h100);
        chk("jal.d2_const", ex_d2, 32'd4);
        // random traffic with random stall/flush
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid, in_pc[32], in_rs1_data[32], in_rs2_data[32], in_rs1_addr[5], in_rs2_addr[5], in_imm[32], in_opcode[7], in_funct3[3], in_funct7_b5[1], in_rd_addr[5]  input  decoded instruction from ID.
REQ-005 stall  input  1  hold stage contents.
REQ-006 flush  input  1  kill the instruction being captured.
REQ-007 mem_fwd_valid[1], mem_fwd_rd[5], mem_fwd_data[32]  input  EX/MEM writeback bypass.
REQ-008 wb_fwd_valid[1], wb_fwd_rd[5], wb_fwd_data[32]  input  MEM/WB writeback bypass.
REQ-009 ex_valid[1], ex_d1[32], ex_d2[32], ex_control[4]  output  registered ALU operands and ALU op code.
REQ-010 ex_rd_addr[5], ex_reg_write[1], ex_store_data[32], ex_illegal[1]  output  registered side-band for later stages.

Function
REQ-011 All outputs SHALL be registered; latency from ID inputs to ex_* outputs is one clk.
REQ-012 On each rising edge: flush=1 -> ex_valid<=0 and all other outputs <=0 (flush beats stall); else stall=1 -> all registers hold; else all registers load the computed next values.
REQ-013 in_valid=0 with no stall/flush -> ex_valid<=0 and ex_reg_write<=0; the other registers may load but SHALL NOT be used downstream.
REQ-014 Forwarded rsX: mem_fwd_valid and mem_fwd_rd==rsX_addr and rsX_addr!=0 -> mem_fwd_data; else the same test on wb -> wb_fwd_data; else in_rsX_data. MEM has priority over WB.
REQ-015 rsX_addr==0 SHALL always yield 0, whatever the bypass and register inputs are.
REQ-016 ALU codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
REQ-017 R-type 0110011: d1=fwd rs1, d2=fwd rs2, control={funct7_b5,funct3}, but only where that pair is a code in REQ-016; any other pair -> illegal.
REQ-018 OP-IMM 0010011: d1=fwd rs1, d2=imm, control={funct3==101 ? funct7_b5 : 0, funct3}. ADDI with imm[30]=1 SHALL NOT yield SUB.
REQ-019 LOAD 0000011 / STORE 0100011: d1=fwd rs1, d2=imm, ADD. ex_store_data=fwd rs2 for all opcodes.
REQ-020 BRANCH 1100011: d1=fwd rs1, d2=fwd rs2. funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> illegal.
REQ-021 LUI 0110111: d1=0, d2=imm, ADD. AUIPC 0010111: d1=pc, d2=imm, ADD.
REQ-022 JAL 1101111 / JALR 1100111: d1=pc, d2=4, ADD (link value).
REQ-023 ex_reg_write=valid & (rd_addr!=0) & opcode in {R, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR}.
REQ-024 Illegal or unknown opcode: ex_illegal=1, ex_valid=in_valid, ex_reg_write=0, control=ADD, d1=d2=0.
REQ-025 Bypass inputs SHALL be sampled only in a capture cycle; a stall holds the previously captured operands.

Reset
REQ-026 rst=1 SHALL immediately force every output register to 0 (ex_control=0000, ex_valid=0), independent of clk.
REQ-027 Reset asserted mid-stall SHALL discard the held instruction; after release the first capture follows REQ-012.

Configuration
REQ-028 Macro EX_OPERAND_FORWARD_EN defined: bypass per REQ-014.
REQ-029 Macro EX_OPERAND_FORWARD_EN undefined: *_fwd_* inputs ignored and operands taken from in_rsX_data (x0 still 0); the hazard unit then stalls on RAW hazards.

Verification
REQ-030 ADD: R-type, funct3=000, funct7_b5=0, rs1=5, rs2=7 -> next cycle d1=5, d2=7, control=0000, reg_write=1.
REQ-031 SRAI: OP-IMM funct3=101, funct7_b5=1, imm=0x403 -> control=1101. ADDI with imm=0x400 -> control=0000.
REQ-032 Forwarding: rs1_addr=3, mem_fwd(rd=3, 0xAA), wb_fwd(rd=3, 0xBB) -> d1=0xAA. With mem_fwd_valid=0 -> d1=0xBB. With rs1_addr=0 -> d1=0.
REQ-033 Stall then flush: stall=1 for 3 cycles -> outputs frozen, including while the bypass data changes; then flush=1 with stall=1 -> ex_valid=0.
REQ-034 Async reset: assert rst between edges -> all outputs 0 before the next edge. Opcode 1111111 -> ex_illegal=1, reg_write=0.
REQ-035 BLTU, rs1=0xFFFFFFFF, rs2=1 -> control=0011. JAL at pc=0x100 -> d1=0x100, d2=4, control=0000.
